mc_control_unit: RTL and testbench
==================================

// Module: mc_control_unit
// PURPOSE
// - Multi-cycle MIPS-subset control FSM. It sequences each instruction through IF/ID/EXE/MEM/WB.
// - It drives PCWre/PCSrc into the PC register and every datapath enable (IR, ALU, RegFile, DataMem).
// - The PC advances only on the rising edge that leaves an instruction's last state.
// PARAMETERS
// - CNT_W     32   width of the retired-instruction counter
// PORTS
// - CLK        in   1      clock, rising edge
// - Reset      in   1      asynchronous, active-low reset
// - opcode     in   6      IR[31:26]; valid from ID onward (IR is loaded at the end of IF)
// - zero       in   1      ALU zero flag; sampled only in EXE_BR
// - PCWre      out  1      PC write enable; PC loads its next value at the edge
// - PCSrc      out  2      00 pc+4, 01 branch target, 10 rs (jr), 11 jump target (j/jal)
// - IRWre      out  1      instruction register load
// - ALUSrcA    out  1      1: shamt as ALU A (sll)
// - ALUSrcB    out  1      1: extended imm16 as ALU B
// - ALUOp      out  3      000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt (signed)
// - ExtSel     out  1      1 sign-extend, 0 zero-extend
// - RegWre     out  1      register file write enable
// - RegDst     out  2      00 $31, 01 rt, 10 rd
// - WrRegDSrc  out  1      0 PC4, 1 DB bus
// - DBDataSrc  out  1      0 ALU result, 1 memory data
// - mRD, mWR   out  1 ea   data memory read / write strobes
// - state      out  3      current FSM state (debug)
// - halted     out  1      1 after halt decode, until reset
// - retired    out  CNT_W  count of instructions completed
// BEHAVIOUR
// - State encoding: IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111.
// - Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000,
//   slt 100110, slti 100111, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
// - Transitions (one per clock):
//   - IF -> ID.
//   - ID: ALU ops -> EXE_AL; beq -> EXE_BR; lw/sw -> EXE_LS; j/jal/jr/unknown -> IF;
//     halt -> ID with halted set.
//   - EXE_AL -> WB_AL -> IF.
//   - EXE_BR -> IF.
//   - EXE_LS -> MEM; MEM -> IF (sw) or WB_LD (lw); WB_LD -> IF.
// - Outputs are combinational from (state, opcode, zero, halted). Every output is 0 unless listed below.
//   - IF: IRWre=1.
//   - ID j: PCWre=1, PCSrc=11.
//   - ID jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
//   - ID jr: PCWre=1, PCSrc=10.
//   - ID unknown opcode: PCWre=1, PCSrc=00 (treated as nop).
//   - ID halt, and any cycle with halted=1: all outputs 0.
//   - EXE_AL and WB_AL share ALU controls: ALUOp per opcode (addi->add, ori->or, slti->slt);
//     ALUSrcA=1 for sll; ALUSrcB=1 for addi/ori/slti; ExtSel=1 except ori.
//   - WB_AL adds: RegWre=1, RegDst=10 (R-type) or 01 (I-type), WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00.
//   - EXE_BR: ALUOp=001, ExtSel=1, PCWre=1, PCSrc = zero ? 01 : 00.
//   - EXE_LS, MEM, WB_LD: ALUOp=000, ALUSrcB=1, ExtSel=1.
//     - MEM sw: mWR=1, PCWre=1, PCSrc=00.
//     - MEM lw: mRD=1.
//     - WB_LD: mRD=1, DBDataSrc=1, RegWre=1, RegDst=01, WrRegDSrc=1, PCWre=1, PCSrc=00.
// - Each instruction asserts PCWre in exactly one cycle. Latencies in cycles:
//   j/jal/jr/nop 2, beq 3, ALU 4, sw 4, lw 5.
// - retired increments at each rising edge where PCWre=1. It wraps from all-ones to 0.
// - Reset low (asynchronous, at any time): state=IF, halted=0, retired=0.
//   - Outputs immediately show the IF decode: IRWre=1, all others 0.
//   - An in-flight instruction is aborted: no PCWre, mWR or RegWre pulse is issued for it.
// BACK-PRESSURE
// - There is no stall input. Memories must be single-cycle.
// TESTING
// - T1: release Reset with opcode=add
//   -> states 000,001,110,111,000; PCWre=1 only in WB_AL with PCSrc=00, RegDst=10; retired 0->1.
// - T2: beq with zero=1 -> EXE_BR shows PCWre=1, PCSrc=01.
//   Repeat with zero=0 -> PCSrc=00. Each takes 3 cycles.
// - T3: lw -> 5 cycles; mRD=1 in MEM and WB_LD; DBDataSrc=1 and RegWre=1 only in WB_LD.
//   sw -> 4 cycles; mWR=1 only in MEM; RegWre never 1.
// - T4: jal -> in ID: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, next state IF.
//   jr -> PCSrc=10. opcode=101010 -> nop with PCSrc=00.
// - T5: halt -> state stays 001, halted=1, all enables 0 for 100 cycles, retired frozen.
//   Pulse Reset low -> state=000, halted=0.
// - T6: assert Reset during MEM of sw -> mWR drops in the same cycle, retired=0.
//   With CNT_W=4, retire 16 nops -> retired wraps to 0.

Source files
------------

// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - control-unit to datapath signal bundle
interface mc_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             zero;
  logic             PCWre;
  logic [1:0]       PCSrc;
  logic             IRWre;
  logic             ALUSrcA;
  logic             ALUSrcB;
  logic [2:0]       ALUOp;
  logic             ExtSel;
  logic             RegWre;
  logic [1:0]       RegDst;
  logic             WrRegDSrc;
  logic             DBDataSrc;
  logic             mRD;
  logic             mWR;
  logic [2:0]       state;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, zero,
    output PCWre, PCSrc, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegWre, RegDst,
           WrRegDSrc, DBDataSrc, mRD, mWR, state, halted, retired
  );

  modport slave (
    output opcode, zero,
    input  PCWre, PCSrc, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegWre, RegDst,
           WrRegDSrc, DBDataSrc, mRD, mWR, state, halted, retired
  );
endinterface

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle MIPS-subset control FSM
module mc_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  mc_control_unit_if.master bus
);
  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000, OP_SLT  = 6'b100110, OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t           state_q;
  logic             halted_q;
  logic [CNT_W-1:0] retired_q;
  logic             is_alu;
  logic             is_itype;
  logic [2:0]       alu_op;

  always_comb begin
    is_alu   = 1'b1;
    is_itype = 1'b0;
    alu_op   = 3'b000;
    case (bus.opcode)
      OP_ADD:  alu_op = 3'b000;
      OP_SUB:  alu_op = 3'b001;
      OP_ADDI: begin alu_op = 3'b000; is_itype = 1'b1; end
      OP_OR:   alu_op = 3'b011;
      OP_AND:  alu_op = 3'b100;
      OP_ORI:  begin alu_op = 3'b011; is_itype = 1'b1; end
      OP_SLL:  alu_op = 3'b010;
      OP_SLT:  alu_op = 3'b101;
      OP_SLTI: begin alu_op = 3'b101; is_itype = 1'b1; end
      default: is_alu = 1'b0;
    endcase
  end

  // Outputs decode straight from state so reset shows the IF controls immediately.
  always_comb begin
    bus.PCWre     = 1'b0;
    bus.PCSrc     = 2'b00;
    bus.IRWre     = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 1'b0;
    bus.ALUOp     = 3'b000;
    bus.ExtSel    = 1'b0;
    bus.RegWre    = 1'b0;
    bus.RegDst    = 2'b00;
    bus.WrRegDSrc = 1'b0;
    bus.DBDataSrc = 1'b0;
    bus.mRD       = 1'b0;
    bus.mWR       = 1'b0;
    if (!halted_q) begin
      case (state_q)
        S_IF: bus.IRWre = 1'b1;
        S_ID: begin
          case (bus.opcode)
            OP_J:   begin bus.PCWre = 1'b1; bus.PCSrc = 2'b11; end
            OP_JAL: begin bus.PCWre = 1'b1; bus.PCSrc = 2'b11; bus.RegWre = 1'b1; end
            OP_JR:  begin bus.PCWre = 1'b1; bus.PCSrc = 2'b10; end
            OP_BEQ, OP_SW, OP_LW, OP_HALT: ;
            default: bus.PCWre = !is_alu;
          endcase
        end
        S_EXE_AL, S_WB_AL: begin
          bus.ALUOp   = alu_op;
          bus.ALUSrcA = (bus.opcode == OP_SLL);
          bus.ALUSrcB = is_itype;
          bus.ExtSel  = (bus.opcode != OP_ORI);
          if (state_q == S_WB_AL) begin
            bus.RegWre    = 1'b1;
            bus.RegDst    = is_itype ? 2'b01 : 2'b10;
            bus.WrRegDSrc = 1'b1;
            bus.PCWre     = 1'b1;
          end
        end
        S_EXE_BR: begin
          bus.ALUOp  = 3'b001;
          bus.ExtSel = 1'b1;
          bus.PCWre  = 1'b1;
          bus.PCSrc  = bus.zero ? 2'b01 : 2'b00;
        end
        S_EXE_LS, S_MEM, S_WB_LD: begin
          bus.ALUSrcB = 1'b1;
          bus.ExtSel  = 1'b1;
          if (state_q == S_MEM) begin
            if (bus.opcode == OP_SW) begin
              bus.mWR   = 1'b1;
              bus.PCWre = 1'b1;
            end else begin
              bus.mRD = 1'b1;
            end
          end
          if (state_q == S_WB_LD) begin
            bus.mRD       = 1'b1;
            bus.DBDataSrc = 1'b1;
            bus.RegWre    = 1'b1;
            bus.RegDst    = 2'b01;
            bus.WrRegDSrc = 1'b1;
            bus.PCWre     = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IF;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else if (!halted_q) begin
      if (bus.PCWre) retired_q <= retired_q + CNT_W'(1);
      case (state_q)
        S_IF: state_q <= S_ID;
        S_ID: begin
          if (is_alu) begin
            state_q <= S_EXE_AL;
          end else begin
            case (bus.opcode)
              OP_BEQ:       state_q <= S_EXE_BR;
              OP_SW, OP_LW: state_q <= S_EXE_LS;
              OP_HALT:      halted_q <= 1'b1;
              default:      state_q <= S_IF;
            endcase
          end
        end
        S_EXE_AL: state_q <= S_WB_AL;
        S_WB_AL:  state_q <= S_IF;
        S_EXE_BR: state_q <= S_IF;
        S_EXE_LS: state_q <= S_MEM;
        S_MEM:    state_q <= (bus.opcode == OP_SW) ? S_IF : S_WB_LD;
        S_WB_LD:  state_q <= S_IF;
      endcase
    end
  end

  assign bus.state   = state_q;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized model-checked bench for mc_control_unit
module tb_mc_control_unit;
  localparam int CNT_W = 4;

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000, OP_SLT  = 6'b100110, OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111, OP_NOP  = 6'b101010;

  typedef struct packed {
    logic       pcwre;
    logic [1:0] pcsrc;
    logic       irwre;
    logic       srca;
    logic       srcb;
    logic [2:0] aluop;
    logic       ext;
    logic       regwre;
    logic [1:0] regdst;
    logic       wrsrc;
    logic       dbsrc;
    logic       mrd;
    logic       mwr;
  } ctl_t;

  typedef struct {
    logic [2:0]       st;
    ctl_t             c;
    logic             h;
    logic [CNT_W-1:0] ret;
  } rec_t;

  typedef struct {
    string nm;
    int    sel;
    int    act;
    int    exp_v;
  } lit_t;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  mc_control_unit_if #(.CNT_W(CNT_W)) bus ();
  mc_control_unit #(.CNT_W(CNT_W)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

  ctl_t act_c;
  assign act_c = {bus.PCWre, bus.PCSrc, bus.IRWre, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                  bus.ExtSel, bus.RegWre, bus.RegDst, bus.WrRegDSrc, bus.DBDataSrc,
                  bus.mRD, bus.mWR};

  logic [5:0] ops [15] = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT,
                           OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL};

  rec_t             exp_arr[$];
  lit_t             lit_q[$];
  int               rd = 0;
  int               lrd = 0;
  bit               check_en = 1'b0;
  event             probe_ev;
  int               n_checks = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] model_ret = '0;

  function automatic int dut_val(input int sel);
    case (sel)
      0:  return int'(bus.state);
      1:  return int'(bus.halted);
      2:  return int'(bus.retired);
      3:  return int'(bus.IRWre);
      4:  return int'(bus.PCWre);
      5:  return int'(bus.PCSrc);
      6:  return int'(bus.RegWre);
      7:  return int'(bus.RegDst);
      8:  return int'(bus.WrRegDSrc);
      9:  return int'(bus.mRD);
      10: return int'(bus.mWR);
      11: return int'(bus.DBDataSrc);
      default: return -1;
    endcase
  endfunction

  task automatic cmp(input string nm, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Literal probes are answered on demand; model records once per cycle on the falling edge.
  initial forever begin
    @(negedge CLK or probe_ev);
    while (lrd < lit_q.size()) begin
      cmp(lit_q[lrd].nm, (lit_q[lrd].sel < 0) ? lit_q[lrd].act : dut_val(lit_q[lrd].sel),
          lit_q[lrd].exp_v);
      lrd++;
    end
    if (CLK == 1'b0) begin
      if (!check_en) begin
        rd = exp_arr.size();
      end else if (rd < exp_arr.size()) begin
        cmp($sformatf("state[%0d]", rd), int'(bus.state), int'(exp_arr[rd].st));
        cmp($sformatf("ctl[%0d]", rd), int'(act_c), int'(exp_arr[rd].c));
        cmp($sformatf("halted[%0d]", rd), int'(bus.halted), int'(exp_arr[rd].h));
        cmp($sformatf("retired[%0d]", rd), int'(bus.retired), int'(exp_arr[rd].ret));
        rd++;
      end
    end
  end

  task automatic push(input logic [2:0] st, input ctl_t c, input logic h);
    rec_t r;
    r.st = st;
    r.c = c;
    r.h = h;
    r.ret = model_ret;
    exp_arr.push_back(r);
    if (c.pcwre) model_ret = model_ret + CNT_W'(1);
  endtask

  task automatic alu_info(input logic [5:0] op, output bit ok, output ctl_t a, output bit itype);
    a = '0;
    ok = 1'b1;
    itype = 1'b0;
    case (op)
      OP_ADD:  a.aluop = 3'd0;
      OP_SUB:  a.aluop = 3'd1;
      OP_ADDI: begin a.aluop = 3'd0; itype = 1'b1; end
      OP_OR:   a.aluop = 3'd3;
      OP_AND:  a.aluop = 3'd4;
      OP_ORI:  begin a.aluop = 3'd3; itype = 1'b1; end
      OP_SLL:  begin a.aluop = 3'd2; a.srca = 1'b1; end
      OP_SLT:  a.aluop = 3'd5;
      OP_SLTI: begin a.aluop = 3'd5; itype = 1'b1; end
      default: ok = 1'b0;
    endcase
    a.srcb = itype;
    a.ext = (op != OP_ORI);
  endtask

  // Per-instruction cycle script: one record per clock the instruction occupies.
  task automatic start_instr(input logic [5:0] op, input logic z, output int len);
    ctl_t c;
    ctl_t a;
    bit   ok;
    bit   it;
    bus.opcode = op;
    bus.zero = z;
    c = '0;
    c.irwre = 1'b1;
    push(3'd0, c, 1'b0);
    alu_info(op, ok, a, it);
    if (ok) begin
      push(3'd1, '0, 1'b0);
      push(3'd6, a, 1'b0);
      c = a;
      c.regwre = 1'b1;
      c.regdst = it ? 2'b01 : 2'b10;
      c.wrsrc = 1'b1;
      c.pcwre = 1'b1;
      push(3'd7, c, 1'b0);
      len = 4;
    end else begin
      case (op)
        OP_BEQ: begin
          push(3'd1, '0, 1'b0);
          c = '0;
          c.aluop = 3'd1;
          c.ext = 1'b1;
          c.pcwre = 1'b1;
          c.pcsrc = z ? 2'b01 : 2'b00;
          push(3'd5, c, 1'b0);
          len = 3;
        end
        OP_SW, OP_LW: begin
          push(3'd1, '0, 1'b0);
          a = '0;
          a.srcb = 1'b1;
          a.ext = 1'b1;
          push(3'd2, a, 1'b0);
          c = a;
          if (op == OP_SW) begin
            c.mwr = 1'b1;
            c.pcwre = 1'b1;
            push(3'd3, c, 1'b0);
            len = 4;
          end else begin
            c.mrd = 1'b1;
            push(3'd3, c, 1'b0);
            c.dbsrc = 1'b1;
            c.regwre = 1'b1;
            c.regdst = 2'b01;
            c.wrsrc = 1'b1;
            c.pcwre = 1'b1;
            push(3'd4, c, 1'b0);
            len = 5;
          end
        end
        OP_HALT: begin
          push(3'd1, '0, 1'b0);
          len = 2;
        end
        default: begin
          c = '0;
          c.pcwre = 1'b1;
          if (op == OP_J) c.pcsrc = 2'b11;
          else if (op == OP_JAL) begin c.pcsrc = 2'b11; c.regwre = 1'b1; end
          else if (op == OP_JR) c.pcsrc = 2'b10;
          push(3'd1, c, 1'b0);
          len = 2;
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input logic [5:0] op, input logic z);
    int len;
    start_instr(op, z, len);
    repeat (len) step();
  endtask

  task automatic lit(input string nm, input int sel, input int e);
    lit_t l;
    l.nm = nm;
    l.sel = sel;
    l.act = 0;
    l.exp_v = e;
    lit_q.push_back(l);
  endtask

  task automatic lit_m(input string nm, input int act, input int e);
    lit_t l;
    l.nm = nm;
    l.sel = -1;
    l.act = act;
    l.exp_v = e;
    lit_q.push_back(l);
  endtask

  task automatic probe();
    -> probe_ev;
    #1;
  endtask

  // Called just after a rising edge; pulls Reset low mid-cycle and checks the async effect.
  task automatic do_reset(input string tag);
    Reset = 1'b0;
    check_en = 1'b0;
    model_ret = '0;
    #1;
    lit({tag, "_state"}, 0, 0);
    lit({tag, "_halted"}, 1, 0);
    lit({tag, "_retired"}, 2, 0);
    lit({tag, "_irwre"}, 3, 1);
    lit({tag, "_pcwre"}, 4, 0);
    lit({tag, "_mwr"}, 10, 0);
    lit({tag, "_regwre"}, 6, 0);
    probe();
    repeat (2) step();
    Reset = 1'b1;
    check_en = 1'b1;
  endtask

  initial begin
    int len;
    bus.opcode = OP_ADD;
    bus.zero = 1'b0;
    #1;
    Reset = 1'b0;
    #1;
    lit("rst_state", 0, 0);
    lit("rst_irwre", 3, 1);
    lit("rst_pcwre", 4, 0);
    lit("rst_retired", 2, 0);
    lit("rst_halted", 1, 0);
    probe();
    repeat (2) step();
    Reset = 1'b1;
    check_en = 1'b1;

    start_instr(OP_ADD, 1'b0, len);
    lit_m("lat_add", len, 4);
    lit("t1_if", 0, 0); probe(); step();
    lit("t1_id", 0, 1); probe(); step();
    lit("t1_exe", 0, 6); lit("t1_exe_pcwre", 4, 0); probe(); step();
    lit("t1_wb", 0, 7); lit("t1_wb_pcwre", 4, 1); lit("t1_wb_pcsrc", 5, 0);
    lit("t1_wb_regdst", 7, 2); lit("t1_wb_ret", 2, 0); probe(); step();
    lit("t1_done", 0, 0); lit("t1_ret", 2, 1); probe();

    start_instr(OP_BEQ, 1'b1, len);
    lit_m("lat_beq", len, 3);
    repeat (2) step();
    lit("t2_st", 0, 5); lit("t2_pcwre", 4, 1); lit("t2_taken", 5, 1); probe(); step();
    start_instr(OP_BEQ, 1'b0, len);
    repeat (2) step();
    lit("t2_nt", 5, 0); probe(); step();

    start_instr(OP_LW, 1'b0, len);
    lit_m("lat_lw", len, 5);
    repeat (3) step();
    lit("t3_mem_mrd", 9, 1); lit("t3_mem_db", 11, 0); lit("t3_mem_rw", 6, 0); probe(); step();
    lit("t3_wb_mrd", 9, 1); lit("t3_wb_db", 11, 1); lit("t3_wb_rw", 6, 1); probe(); step();
    start_instr(OP_SW, 1'b0, len);
    lit_m("lat_sw", len, 4);
    repeat (len) step();

    start_instr(OP_JAL, 1'b0, len);
    lit_m("lat_jal", len, 2);
    step();
    lit("t4_jal_pcwre", 4, 1); lit("t4_jal_pcsrc", 5, 3); lit("t4_jal_rw", 6, 1);
    lit("t4_jal_dst", 7, 0); lit("t4_jal_wrs", 8, 0); probe(); step();
    lit("t4_jal_next", 0, 0); probe();
    start_instr(OP_JR, 1'b0, len);
    step();
    lit("t4_jr_pcsrc", 5, 2); probe(); step();
    start_instr(OP_NOP, 1'b0, len);
    step();
    lit("t4_nop_pcwre", 4, 1); lit("t4_nop_pcsrc", 5, 0); probe(); step();

    repeat (150) begin
      logic [5:0] op;
      int         k;
      k = int'($urandom_range(0, 19));
      if (k < 15) op = ops[k];
      else op = 6'($urandom_range(0, 62));
      run(op, 1'($urandom_range(0, 1)));
    end

    start_instr(OP_HALT, 1'b0, len);
    repeat (2) step();
    repeat (100) push(3'd1, '0, 1'b1);
    repeat (100) step();
    lit("t5_halted", 1, 1); lit("t5_state", 0, 1); lit("t5_irwre", 3, 0);
    lit("t5_ret", 2, int'(model_ret)); probe();
    do_reset("t5_rst");

    start_instr(OP_SW, 1'b0, len);
    repeat (3) step();
    lit("t6_mem_mwr", 10, 1); probe();
    do_reset("t6_rst");

    repeat (15) run(OP_NOP, 1'b0);
    lit("wrap_15", 2, 15); probe();
    run(OP_NOP, 1'b0);
    lit("wrap_0", 2, 0); probe();

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
